// File: rtl/rvx_timer_responder_pkg.sv
// Shared constants for the memory-mapped machine timer.
//   - word offsets (rw_address[4:2]) of the register map
//   - CONTROL register bit positions
//   - reset values of the 64-bit timer registers
package rvx_timer_responder_pkg;

  localparam logic [2:0] RVX_TIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] RVX_TIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] RVX_TIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] RVX_TIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] RVX_TIMER_CONTROL     = 3'd4;

  localparam int RVX_TIMER_CTRL_ENABLE_BIT   = 0;
  localparam int RVX_TIMER_CTRL_PRESCALE_LSB = 8;

  localparam logic [63:0] RVX_TIMER_MTIME_RESET    = 64'h0000_0000_0000_0000;
  localparam logic [63:0] RVX_TIMER_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rvx_timer_strobe_merge.sv
// Combinational byte merge for a 32-bit register word.
//   old_word     : current register contents
//   write_data   : new data from the bus
//   write_strobe : byte enables, bit b selects byte b of write_data
//   merged_word  : old_word with the enabled bytes replaced
module rvx_timer_strobe_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (write_strobe[b]) begin
        merged_word[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/rvx_timer_responder.sv
// Memory-mapped machine timer on the data-bus responder side.
// Holds mtime, mtimecmp and CONTROL; answers every read/write request with a
// single-cycle response pulse one clock after the request is sampled.
//   clock, reset_n       : clock, asynchronous active-low reset
//   rw_address           : byte address, [4:2] selects the word
//   read_request         : read request, answered by read_response/read_data
//   write_request        : write request with write_data/write_strobe,
//                          answered by write_response
//   memory_mapped_timer  : live mtime value
//   irq_timer            : level interrupt, mtime >= mtimecmp
module rvx_timer_responder
  import rvx_timer_responder_pkg::*;
#(
  parameter int          PRESCALER_WIDTH = 16,
  parameter logic [31:0] CONTROL_RESET   = 32'h00000001
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rw_address,
  input  logic        read_request,
  output logic [31:0] read_data,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic [63:0] memory_mapped_timer,
  output logic        irq_timer
);

  localparam int PW   = PRESCALER_WIDTH;
  localparam int PLSB = RVX_TIMER_CTRL_PRESCALE_LSB;
  localparam int PMSB = RVX_TIMER_CTRL_PRESCALE_LSB + PRESCALER_WIDTH - 1;
  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          enable_q, enable_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [PW-1:0] counter_q, counter_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          read_response_q, read_response_d;
  logic          write_response_q, write_response_d;
  logic          irq_q, irq_d;

  logic [2:0]  word_sel;
  logic        unused_addr_bits;
  logic [31:0] control_word;
  logic [31:0] mtime_lo_merged, mtime_hi_merged;
  logic [31:0] cmp_lo_merged, cmp_hi_merged, control_merged;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_control;
  logic        tick;

  assign word_sel         = rw_address[4:2];
  assign unused_addr_bits = ^rw_address[1:0];

  always_comb begin
    control_word                            = '0;
    control_word[RVX_TIMER_CTRL_ENABLE_BIT] = enable_q;
    control_word[PMSB:PLSB]                 = prescale_q;
  end

  rvx_timer_strobe_merge u_merge_mtime_lo (
    .old_word(mtime_q[31:0]), .write_data(write_data),
    .write_strobe(write_strobe), .merged_word(mtime_lo_merged));
  rvx_timer_strobe_merge u_merge_mtime_hi (
    .old_word(mtime_q[63:32]), .write_data(write_data),
    .write_strobe(write_strobe), .merged_word(mtime_hi_merged));
  rvx_timer_strobe_merge u_merge_cmp_lo (
    .old_word(mtimecmp_q[31:0]), .write_data(write_data),
    .write_strobe(write_strobe), .merged_word(cmp_lo_merged));
  rvx_timer_strobe_merge u_merge_cmp_hi (
    .old_word(mtimecmp_q[63:32]), .write_data(write_data),
    .write_strobe(write_strobe), .merged_word(cmp_hi_merged));
  rvx_timer_strobe_merge u_merge_control (
    .old_word(control_word), .write_data(write_data),
    .write_strobe(write_strobe), .merged_word(control_merged));

  assign wr_mtime_lo = write_request && (word_sel == RVX_TIMER_MTIME_LO);
  assign wr_mtime_hi = write_request && (word_sel == RVX_TIMER_MTIME_HI);
  assign wr_cmp_lo   = write_request && (word_sel == RVX_TIMER_MTIMECMP_LO);
  assign wr_cmp_hi   = write_request && (word_sel == RVX_TIMER_MTIMECMP_HI);
  assign wr_control  = write_request && (word_sel == RVX_TIMER_CONTROL);

  // Terminal count of the prescaler; only meaningful while enabled.
  assign tick = enable_q && (counter_q == prescale_q);

  always_comb begin
    mtime_d          = mtime_q;
    mtimecmp_d       = mtimecmp_q;
    enable_d         = enable_q;
    prescale_d       = prescale_q;
    counter_d        = counter_q;
    read_data_d      = '0;
    read_response_d  = read_request;
    write_response_d = write_request;

    if (enable_q) begin
      counter_d = tick ? '0 : counter_q + CNT_ONE;
    end

    // A software write to either mtime word takes priority over the
    // increment; the increment for that cycle is simply dropped.
    if (wr_mtime_lo) begin
      mtime_d = {mtime_q[63:32], mtime_lo_merged};
    end else if (wr_mtime_hi) begin
      mtime_d = {mtime_hi_merged, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_cmp_lo) begin
      mtimecmp_d = {mtimecmp_q[63:32], cmp_lo_merged};
    end else if (wr_cmp_hi) begin
      mtimecmp_d = {cmp_hi_merged, mtimecmp_q[31:0]};
    end

    if (wr_control) begin
      enable_d   = control_merged[RVX_TIMER_CTRL_ENABLE_BIT];
      prescale_d = control_merged[PMSB:PLSB];
      counter_d  = '0;
    end

    // Reads see the pre-write register contents.
    if (read_request) begin
      unique case (word_sel)
        RVX_TIMER_MTIME_LO:    read_data_d = mtime_q[31:0];
        RVX_TIMER_MTIME_HI:    read_data_d = mtime_q[63:32];
        RVX_TIMER_MTIMECMP_LO: read_data_d = mtimecmp_q[31:0];
        RVX_TIMER_MTIMECMP_HI: read_data_d = mtimecmp_q[63:32];
        RVX_TIMER_CONTROL:     read_data_d = control_word;
        default:               read_data_d = '0;
      endcase
    end

    // Compare on next-state values so irq tracks mtime with no extra lag.
    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q          <= RVX_TIMER_MTIME_RESET;
      mtimecmp_q       <= RVX_TIMER_MTIMECMP_RESET;
      enable_q         <= CONTROL_RESET[RVX_TIMER_CTRL_ENABLE_BIT];
      prescale_q       <= CONTROL_RESET[PMSB:PLSB];
      counter_q        <= '0;
      read_data_q      <= '0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      mtime_q          <= mtime_d;
      mtimecmp_q       <= mtimecmp_d;
      enable_q         <= enable_d;
      prescale_q       <= prescale_d;
      counter_q        <= counter_d;
      read_data_q      <= read_data_d;
      read_response_q  <= read_response_d;
      write_response_q <= write_response_d;
      irq_q            <= irq_d;
    end
  end

  assign read_data           = read_data_q;
  assign read_response       = read_response_q;
  assign write_response      = write_response_q;
  assign memory_mapped_timer = mtime_q;
  assign irq_timer           = irq_q;

endmodule

// File: tb/tb_rvx_timer_responder.sv
// Bench for rvx_timer_responder: a register-level reference model tracks
// the timer, a negedge process compares every output each cycle, and
// directed sequences pin known literal values.
module tb_rvx_timer_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rw_address = '0;
  logic        read_request = 1'b0;
  logic [31:0] read_data;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [63:0] memory_mapped_timer;
  logic        irq_timer;

  rvx_timer_responder dut (
    .clock(clock), .reset_n(reset_n), .rw_address(rw_address),
    .read_request(read_request), .read_data(read_data),
    .read_response(read_response), .write_data(write_data),
    .write_strobe(write_strobe), .write_request(write_request),
    .write_response(write_response),
    .memory_mapped_timer(memory_mapped_timer), .irq_timer(irq_timer));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic        m_en;
  int unsigned m_ps, m_cnt;
  logic        m_irq;
  logic [31:0] e_rdata;
  logic        e_rresp, e_wresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time = 64'h0; m_cmp = '1; m_en = 1'b1; m_ps = 0; m_cnt = 0; m_irq = 1'b0;
    e_rdata = '0; e_rresp = 1'b0; e_wresp = 1'b0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] w);
    case (w)
      3'd0: return m_time[31:0];
      3'd1: return m_time[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {8'h00, m_ps[15:0], 7'h00, m_en};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural behaviour.
  task automatic model_step(input logic rd, input logic wr, input logic [4:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    logic [2:0]  w;
    logic [63:0] nt, nc;
    logic [31:0] cw;
    logic        tk;
    w = a[4:2];
    e_rresp = rd;
    e_rdata = rd ? m_read(w) : 32'h0;
    e_wresp = wr;
    tk = m_en && (m_cnt == m_ps);
    nt = tk ? m_time + 64'd1 : m_time;
    nc = m_cmp;
    if (m_en) m_cnt = tk ? 0 : m_cnt + 1;
    if (wr) begin
      case (w)
        3'd0: nt = {m_time[63:32], bytes_merge(m_time[31:0], d, s)};
        3'd1: nt = {bytes_merge(m_time[63:32], d, s), m_time[31:0]};
        3'd2: nc = {m_cmp[63:32], bytes_merge(m_cmp[31:0], d, s)};
        3'd3: nc = {bytes_merge(m_cmp[63:32], d, s), m_cmp[31:0]};
        3'd4: begin
          cw = bytes_merge(m_read(3'd4), d, s);
          m_en = cw[0];
          m_ps = int'(cw[23:8]);
          m_cnt = 0;
        end
        default: ;
      endcase
    end
    m_time = nt;
    m_cmp = nc;
    m_irq = (nt >= nc);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("read_response", 64'(read_response), 64'(e_rresp));
      check("read_data", 64'(read_data), 64'(e_rdata));
      check("write_response", 64'(write_response), 64'(e_wresp));
      check("memory_mapped_timer", memory_mapped_timer, m_time);
      check("irq_timer", 64'(irq_timer), 64'(m_irq));
    end
  end

  task automatic cycle(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    read_request = rd; write_request = wr; rw_address = a;
    write_data = d; write_strobe = s;
    @(posedge clock);
    model_step(rd, wr, a, d, s);
    @(negedge clock);
    read_request = 1'b0; write_request = 1'b0;
  endtask

  task automatic wr_word(input int w, input logic [31:0] d);
    cycle(1'b0, 1'b1, 5'(w * 4), d, 4'hF);
  endtask

  task automatic rd_word(input int w);
    cycle(1'b1, 1'b0, 5'(w * 4), 32'h0, 4'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] ref_words[5];
    logic [31:0] wd;
    logic [4:0]  ad;
    ref_words[0] = 32'h0; ref_words[1] = 32'h0; ref_words[2] = 32'hFFFFFFFF;
    ref_words[3] = 32'hFFFFFFFF; ref_words[4] = 32'h00000001;

    model_reset();
    repeat (2) @(negedge clock);
    check("reset_irq", 64'(irq_timer), 64'h0);
    check("reset_read_response", 64'(read_response), 64'h0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset values read back
    for (int w = 0; w < 5; w++) begin
      rd_word(w);
      check("reset_read_resp_pulse", 64'(read_response), 64'h1);
      check("reset_word", 64'(read_data), 64'(ref_words[w]));
    end
    check("reset_irq_after_reads", 64'(irq_timer), 64'h0);
    idle();
    check("read_response_drops", 64'(read_response), 64'h0);

    // Prescale 3: one increment per four enabled clocks
    wr_word(4, 32'h0);
    wr_word(0, 32'h0);
    wr_word(1, 32'h0);
    wr_word(4, 32'h00000301);
    check("write_response_pulse", 64'(write_response), 64'h1);
    repeat (40) idle();
    rd_word(0);
    checks++;
    if (read_data < 32'd9 || read_data > 32'd11) begin
      errors++;
      $display("FAIL prescale_count actual=%0d required=10+/-1", read_data);
    end

    // Carry wrap with prescale 0 and mtimecmp 0
    wr_word(4, 32'h00000001);
    wr_word(2, 32'h0);
    wr_word(3, 32'h0);
    wr_word(1, 32'hFFFFFFFF);
    wr_word(0, 32'hFFFFFFFE);
    check("wrap_pre", memory_mapped_timer, 64'hFFFFFFFF_FFFFFFFE);
    check("wrap_irq0", 64'(irq_timer), 64'h1);
    idle();
    check("wrap_max", memory_mapped_timer, 64'hFFFFFFFF_FFFFFFFF);
    check("wrap_irq1", 64'(irq_timer), 64'h1);
    idle();
    check("wrap_zero", memory_mapped_timer, 64'h0);
    check("wrap_irq2", 64'(irq_timer), 64'h1);

    // Compare at 0x20
    wr_word(4, 32'h0);
    wr_word(3, 32'h0);
    wr_word(2, 32'h20);
    wr_word(1, 32'h0);
    wr_word(0, 32'h0);
    check("cmp_irq_low", 64'(irq_timer), 64'h0);
    wr_word(4, 32'h00000001);
    repeat (31) idle();
    check("cmp_before", memory_mapped_timer, 64'h1F);
    check("cmp_irq_before", 64'(irq_timer), 64'h0);
    idle();
    check("cmp_reach", memory_mapped_timer, 64'h20);
    check("cmp_irq_rise", 64'(irq_timer), 64'h1);
    wr_word(2, 32'h100);
    check("cmp_irq_clear", 64'(irq_timer), 64'h0);
    check("cmp_mtime_runs", memory_mapped_timer, 64'h21);

    // Strobed write
    wr_word(4, 32'h0);
    wr_word(0, 32'h11223344);
    cycle(1'b0, 1'b1, 5'h00, 32'hAABBCCDD, 4'b0101);
    rd_word(0);
    check("strobe_merge", 64'(read_data), 64'h11BB33DD);
    cycle(1'b0, 1'b1, 5'h04, 32'h12345678, 4'b0000);
    check("zero_strobe_ack", 64'(write_response), 64'h1);

    // Simultaneous read and write of CONTROL
    wr_word(4, 32'h00000701);
    cycle(1'b1, 1'b1, 5'h10, 32'h0, 4'hF);
    check("collide_read_old", 64'(read_data), 64'h701);
    check("collide_rresp", 64'(read_response), 64'h1);
    check("collide_wresp", 64'(write_response), 64'h1);
    rd_word(4);
    check("collide_new", 64'(read_data), 64'h0);

    // Write MTIME_LO on a terminal-count cycle
    wr_word(0, 32'hFFFFFFFF);
    wr_word(1, 32'h5);
    wr_word(4, 32'h00000001);
    wr_word(0, 32'h00001234);
    check("tc_write_wins", memory_mapped_timer, 64'h00000005_00001234);
    idle();
    check("tc_then_count", memory_mapped_timer, 64'h00000005_00001235);
    rd_word(1);
    check("tc_hi_kept", 64'(read_data), 64'h5);

    // Unmapped words read zero, still acknowledged
    cycle(1'b1, 1'b1, 5'h1C, 32'hFFFFFFFF, 4'hF);
    check("unmapped_read", 64'(read_data), 64'h0);
    check("unmapped_wresp", 64'(write_response), 64'h1);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      ad = 5'($urandom_range(0, 31));
      wd = $urandom;
      if (ad[4:2] == 3'd4) wd = wd & 32'h000003FF;
      if (ad[4:2] == 3'd1 || ad[4:2] == 3'd3) wd = wd & 32'h00000003;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ad, wd,
            4'($urandom_range(0, 15)));
    end

    // Reset while responses are pending
    read_request = 1'b1; write_request = 1'b1; rw_address = 5'h10;
    write_data = 32'h0; write_strobe = 4'hF;
    @(posedge clock);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_kill_rresp", 64'(read_response), 64'h0);
    check("rst_kill_wresp", 64'(write_response), 64'h0);
    read_request = 1'b0; write_request = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle();
    check("post_rst_rresp", 64'(read_response), 64'h0);
    check("post_rst_wresp", 64'(write_response), 64'h0);
    check("post_rst_mtime", memory_mapped_timer, 64'h1);
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
